// File: rtl/usb_crc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// usb_crc_pkg : shared CRC-16/USB constants, FSM state type, bit step
// Rev 1.0
// ------------------------------------------------------------------
package usb_crc_pkg;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    OUT_LO = 2'd2,
    OUT_HI = 2'd3
  } crc_state_t;

  // One reflected CRC step for a single data bit.
  function automatic logic [15:0] crc16_bit_step(input logic [15:0] crc, input logic b);
    logic [15:0] nxt;
    nxt = crc >> 1;
    if (crc[0] ^ b) nxt = nxt ^ CRC16_POLY_REFL;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_crc16_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// tx_crc16_gen_if : byte-in / CRC-pop handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface tx_crc16_gen_if;

  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       crc_valid;
  logic [7:0] crc_out;
  logic       crc_pop;
  logic       busy;
  logic [6:0] byte_count;

  modport master (
    output clear, in_valid, in_data, crc_pop,
    input  in_ready, crc_valid, crc_out, busy, byte_count
  );

  modport slave (
    input  clear, in_valid, in_data, crc_pop,
    output in_ready, crc_valid, crc_out, busy, byte_count
  );

endinterface
`default_nettype wire

// File: rtl/crc16_serial_core.sv
`default_nettype none
// ------------------------------------------------------------------
// crc16_serial_core : bit-serial CRC-16/USB register with byte latch
// Rev 1.0
// ------------------------------------------------------------------
module crc16_serial_core
  import usb_crc_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic        init,
  input  logic [7:0]  data,
  output logic        done,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit_cnt;
  logic        r_active;

  // init dominates load so an abort can never start a new byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_crc     <= CRC16_INIT;
      r_shreg   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_active  <= 1'b0;
    end else if (init) begin
      r_crc     <= CRC16_INIT;
      r_bit_cnt <= 3'd0;
      r_active  <= 1'b0;
    end else if (load) begin
      r_shreg   <= data;
      r_bit_cnt <= 3'd0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      r_crc     <= crc16_bit_step(r_crc, r_shreg[0]);
      r_shreg   <= r_shreg >> 1;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) r_active <= 1'b0;
    end
  end

  assign done = r_active && (r_bit_cnt == 3'd7);
  assign crc  = r_crc;

endmodule
`default_nettype wire

// File: rtl/tx_crc16_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tx_crc16_gen : regenerates USB DATA CRC16 over the encrypted payload
// Rev 1.0
// ------------------------------------------------------------------
module tx_crc16_gen
  import usb_crc_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 16
) (
  input  logic          clk,
  input  logic          n_rst,
  tx_crc16_gen_if.slave bus
);

  localparam logic [6:0] c_payload_bytes = 7'(PAYLOAD_BYTES);

  crc_state_t  r_state;
  logic [6:0]  r_byte_count;
  logic        w_load;
  logic        w_init;
  logic        w_done;
  logic [15:0] w_crc;

  assign w_load = !bus.clear && (r_state == IDLE) && bus.in_valid;
  assign w_init = bus.clear || ((r_state == OUT_HI) && bus.crc_pop);

  crc16_serial_core u_core (
    .clk  (clk),
    .n_rst(n_rst),
    .load (w_load),
    .init (w_init),
    .data (bus.in_data),
    .done (w_done),
    .crc  (w_crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_byte_count <= 7'd0;
    end else if (bus.clear) begin
      r_state      <= IDLE;
      r_byte_count <= 7'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state <= SHIFT;
            if (r_byte_count < c_payload_bytes) r_byte_count <= r_byte_count + 7'd1;
          end
        end
        SHIFT: begin
          if (w_done) r_state <= (r_byte_count < c_payload_bytes) ? IDLE : OUT_LO;
        end
        OUT_LO: begin
          if (bus.crc_pop) r_state <= OUT_HI;
        end
        OUT_HI: begin
          if (bus.crc_pop) begin
            r_state      <= IDLE;
            r_byte_count <= 7'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on this cycle's inputs
  assign bus.in_ready   = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.crc_valid  = (r_state == OUT_LO) || (r_state == OUT_HI);
  assign bus.byte_count = r_byte_count;
  assign bus.crc_out    = (r_state == OUT_LO) ? ~w_crc[7:0]  :
                          (r_state == OUT_HI) ? ~w_crc[15:8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tx_crc16_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_tx_crc16_gen : randomized self-checking bench with bytewise CRC model
// Rev 1.0
// ------------------------------------------------------------------
module tb_tx_crc16_gen;
  import usb_crc_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  tx_crc16_gen_if bus9();
  tx_crc16_gen_if bus16();

  tx_crc16_gen #(.PAYLOAD_BYTES(9))  dut9  (.clk(clk), .n_rst(n_rst), .bus(bus9));
  tx_crc16_gen #(.PAYLOAD_BYTES(16)) dut16 (.clk(clk), .n_rst(n_rst), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pkt[$];

  // Table-free bytewise CRC-16/USB over pkt; returns raw register (not inverted)
  function automatic logic [15:0] crc_reg();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pkt[i]) begin
      c = c ^ {8'h00, pkt[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic idle_inputs();
    bus9.clear = 0;  bus9.in_valid = 0;  bus9.in_data = 0;  bus9.crc_pop = 0;
    bus16.clear = 0; bus16.in_valid = 0; bus16.in_data = 0; bus16.crc_pop = 0;
  endtask

  task automatic random_packet();
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic send16(input logic [7:0] b);
    int cnt;
    cnt = 0;
    bus16.in_valid = 1'b1;
    bus16.in_data  = b;
    while (bus16.in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (bus16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send16_ready_timeout: in_ready=%b required 1", bus16.in_ready);
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
  endtask

  task automatic collect16(output logic [7:0] lo, output logic [7:0] hi);
    int cnt;
    cnt = 0;
    while (bus16.crc_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (bus16.crc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL crc_valid_timeout: crc_valid=%b required 1", bus16.crc_valid);
    end
    lo = bus16.crc_out;
    bus16.crc_pop = 1'b1;
    @(negedge clk);
    hi = bus16.crc_out;
    @(negedge clk);
    bus16.crc_pop = 1'b0;
  endtask

  task automatic check_crc16(input string name, input logic [7:0] lo, input logic [7:0] hi);
    logic [15:0] exp;
    exp = ~crc_reg();
    n_checks++;
    if ({hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL %s: crc=%h required %h", name, {hi, lo}, exp);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus16.clear = 1'($urandom); bus16.in_valid = 1'($urandom);
      bus16.in_data = 8'($urandom); bus16.crc_pop = 1'($urandom);
      bus9.in_valid = 1'($urandom); bus9.crc_pop = 1'($urandom);
      #1;
      n_checks++;
      if ({bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.busy, bus16.byte_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 7'd0}) begin
        n_fail++;
        $display("FAIL reset16: rdy=%b vld=%b out=%h busy=%b cnt=%0d required 1 0 00 0 0",
                 bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.busy, bus16.byte_count);
      end
      n_checks++;
      if ({bus9.in_ready, bus9.crc_valid, bus9.busy, bus9.byte_count} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
        n_fail++;
        $display("FAIL reset9: rdy=%b vld=%b busy=%b cnt=%0d required 1 0 0 0",
                 bus9.in_ready, bus9.crc_valid, bus9.busy, bus9.byte_count);
      end
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_check_value();
    int cnt;
    for (int i = 0; i < 9; i++) begin
      bus9.in_valid = 1'b1;
      bus9.in_data  = 8'h31 + 8'(i);
      cnt = 0;
      while (bus9.in_ready !== 1'b1 && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      @(negedge clk);
      bus9.in_valid = 1'b0;
    end
    cnt = 0;
    while (bus9.crc_valid !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (bus9.crc_out !== 8'hC8) begin
      n_fail++;
      $display("FAIL check_lo: crc_out=%h required c8", bus9.crc_out);
    end
    bus9.crc_pop = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus9.crc_out !== 8'hB4) begin
      n_fail++;
      $display("FAIL check_hi: crc_out=%h required b4", bus9.crc_out);
    end
    @(negedge clk);
    bus9.crc_pop = 1'b0;
    n_checks++;
    if ({bus9.crc_valid, bus9.crc_out, bus9.byte_count, bus9.busy} !== {1'b0, 8'h00, 7'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL check_done: vld=%b out=%h cnt=%0d busy=%b required 0 00 0 0",
               bus9.crc_valid, bus9.crc_out, bus9.byte_count, bus9.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, prev, idx;
    logic [7:0] lo, hi;
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
    cyc = 0; prev = -1; idx = 0;
    bus16.in_valid = 1'b1;
    bus16.in_data  = pkt[0];
    while (idx < 16 && cyc < 400) begin
      if (bus16.in_ready === 1'b1) begin
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev !== 9) begin
            n_fail++;
            $display("FAIL b2b_ready_spacing: gap=%0d required 9", cyc - prev);
          end
        end
        prev = cyc;
        idx++;
        @(negedge clk); cyc++;
        if (idx < 16) bus16.in_data = pkt[idx];
        else bus16.in_valid = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    while (bus16.crc_valid !== 1'b1 && cyc < prev + 30) begin
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (cyc - prev !== 9) begin
      n_fail++;
      $display("FAIL b2b_valid_latency: latency=%0d required 9", cyc - prev);
    end
    collect16(lo, hi);
    check_crc16("b2b_crc", lo, hi);
    pkt.push_back(lo);
    pkt.push_back(hi);
    n_checks++;
    if (crc_reg() !== CRC16_RESIDUE) begin
      n_fail++;
      $display("FAIL b2b_residue: reg=%h required %h", crc_reg(), CRC16_RESIDUE);
    end
  endtask

  task automatic test_random_packets();
    logic [7:0] lo, hi;
    for (int p = 0; p < 3; p++) begin
      random_packet();
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send16(pkt[i]);
        n_checks++;
        if (bus16.byte_count !== 7'(i + 1)) begin
          n_fail++;
          $display("FAIL rand_byte_count: cnt=%0d required %0d", bus16.byte_count, i + 1);
        end
      end
      collect16(lo, hi);
      check_crc16("rand_crc", lo, hi);
    end
  endtask

  task automatic test_clear();
    logic [7:0] lo, hi;
    random_packet();
    for (int i = 0; i < 5; i++) send16(pkt[i]);
    repeat (4) @(negedge clk);
    bus16.clear = 1'b1;
    @(negedge clk);
    bus16.clear = 1'b0;
    n_checks++;
    if ({bus16.busy, bus16.in_ready, bus16.byte_count} !== {1'b0, 1'b1, 7'd0}) begin
      n_fail++;
      $display("FAIL clear_state: busy=%b rdy=%b cnt=%0d required 0 1 0",
               bus16.busy, bus16.in_ready, bus16.byte_count);
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) send16(pkt[i]);
    collect16(lo, hi);
    check_crc16("clear_crc", lo, hi);
  endtask

  task automatic test_pop_ignore();
    logic [7:0] lo;
    logic [15:0] exp;
    int cnt;
    random_packet();
    exp = ~crc_reg();
    for (int i = 0; i < 16; i++) send16(pkt[i]);
    cnt = 0;
    while (bus16.crc_valid !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    lo = bus16.crc_out;
    n_checks++;
    if (lo !== exp[7:0]) begin
      n_fail++;
      $display("FAIL pop_lo: crc_out=%h required %h", lo, exp[7:0]);
    end
    bus16.in_valid = 1'b1;
    bus16.in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus16.in_ready, bus16.crc_valid, bus16.byte_count} !== {1'b0, 1'b1, 7'd16}) begin
        n_fail++;
        $display("FAIL pop_hold_lo: rdy=%b vld=%b cnt=%0d required 0 1 16",
                 bus16.in_ready, bus16.crc_valid, bus16.byte_count);
      end
    end
    bus16.crc_pop = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus16.crc_out, bus16.byte_count, bus16.in_ready} !== {exp[15:8], 7'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL pop_hi: out=%h cnt=%0d rdy=%b required %h 16 0",
               bus16.crc_out, bus16.byte_count, bus16.in_ready, exp[15:8]);
    end
    bus16.in_valid = 1'b0;
    @(negedge clk);
    bus16.crc_pop = 1'b0;
    n_checks++;
    if ({bus16.crc_valid, bus16.busy, bus16.byte_count} !== {1'b0, 1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL pop_done: vld=%b busy=%b cnt=%0d required 0 0 0",
               bus16.crc_valid, bus16.busy, bus16.byte_count);
    end
    bus16.crc_pop = 1'b1;
    @(negedge clk);
    bus16.crc_pop = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus16.busy, bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.byte_count} !== {1'b0, 1'b1, 1'b0, 8'h00, 7'd0}) begin
      n_fail++;
      $display("FAIL pop_third_ignored: busy=%b rdy=%b vld=%b out=%h cnt=%0d required 0 1 0 00 0",
               bus16.busy, bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.byte_count);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] lo, hi;
    random_packet();
    for (int i = 0; i < 3; i++) send16(pkt[i]);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if ({bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.busy, bus16.byte_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b out=%h busy=%b cnt=%0d required 1 0 00 0 0",
               bus16.in_ready, bus16.crc_valid, bus16.crc_out, bus16.busy, bus16.byte_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send16(pkt[i]);
    collect16(lo, hi);
    check_crc16("async_reset_crc", lo, hi);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_check_value();
    test_back_to_back();
    test_random_packets();
    test_clear();
    test_pop_ignore();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
